// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  localparam int STATS_W = 16;
  // Index width sized for the largest supported requester count (8).
  localparam int IDX_W = 3;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of elig at or after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // First pass covers indices at/after the pointer, second pass wraps to the low ones.
  always_comb begin
    gnt_oh = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && elig[i] && (i >= int'(ptr))) begin
        valid     = 1'b1;
        gnt_oh[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && elig[i]) begin
        valid     = 1'b1;
        gnt_oh[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ req/gnt producers.
// Define FIFO_ARB_STATS_EN to add the wr_count / stall_count statistics outputs.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          arb_err,
  output arb_state_e                    dbg_state
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]            wr_count,
  output logic [STATS_W-1:0]            stall_count
`endif
);

  // Handshake: a producer holds req[i] and its data slice until the cycle gnt[i]=1;
  // that cycle the data is on fifo_din with fifo_wr_en=1 and the producer may move on.

  arb_state_e             state;
  arb_state_e             state_nxt;
  logic [IDX_W-1:0]       ptr;
  logic [NUM_REQ-1:0]     elig;
  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   stall;
  logic                   wr_pend;
  logic [DATA_WIDTH-1:0]  pick_data;

  // The requester being granted right now is masked so a held req is not served twice.
  assign elig  = req & ~gnt;
  assign stall = fifo_full | (fifo_almostfull & fifo_wr_en);

  rr_pick #(.N(NUM_REQ)) u_pick (
    .elig   (elig),
    .ptr    (ptr),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (pick_valid) state_nxt = stall ? STALL : WRITE;
  end

  always_comb begin
    fifo_wr_en = (state == WRITE);
    dbg_state  = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      fifo_din <= '0;
      ptr      <= '0;
    end else if (state_nxt == WRITE) begin
      gnt      <= pick_oh;
      fifo_din <= pick_data;
      ptr      <= rr_next(pick_idx, NUM_REQ);
    end else begin
      gnt      <= '0;
    end
  end

  // wr_pend remembers last cycle's write so this cycle's wr_ack can be checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= 1'b0;
      arb_err <= 1'b0;
    end else begin
      wr_pend <= fifo_wr_en;
      if (fifo_overflow || (wr_pend && !fifo_wr_ack)) arb_err <= 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_wr_en) wr_count <= wr_count + STATS_W'(1);
      if ((state == STALL) && (stall_count != '1)) stall_count <= stall_count + STATS_W'(1);
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the team's synchronous FIFO between NUM_REQ producers. Each producer uses a req/gnt handshake. The arbiter issues at most one registered write per cycle, throttles on the FIFO's full/almostfull flags so no overflow is ever caused, and checks the FIFO's wr_ack/overflow responses. It sits between producer blocks and the FIFO write side; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, FIFO data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester write request; level, held until granted.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot registered grant pulse; high in the same cycle the write is presented.
- fifo_wr_en  out  1  registered write enable to FIFO.
- fifo_din  out  DATA_WIDTH  registered write data to FIFO.
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO has exactly one free slot.
- fifo_wr_ack  in  1  FIFO acknowledge, one cycle after an accepted write.
- fifo_overflow  in  1  FIFO rejected a write.
- arb_err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0): gnt=0, fifo_wr_en=0, fifo_din=0, arb_err=0, rr pointer=0 (requester 0 has top priority), state=IDLE.
- Eligible set = req & ~gnt. The requester granted in the current cycle is masked, so a held req is never double-granted.
- stall = fifo_full | (fifo_almostfull & fifo_wr_en). This is conservative; concurrent FIFO reads are ignored.
- Each cycle, if !stall and the eligible set is non-zero:
  - pick the first eligible index at or after the rr pointer, wrapping modulo NUM_REQ;
  - next cycle drive gnt[k]=1, fifo_wr_en=1, fifo_din=req_data slice k;
  - rr pointer becomes (k+1) mod NUM_REQ.
- Otherwise next cycle gnt=0, fifo_wr_en=0, and fifo_din holds its value.
- Latency: req rising in cycle t with no contention and no stall gives gnt/fifo_wr_en in cycle t+1. Back-to-back writes run at one per cycle across different requesters. A single requester gets at most one write every 2 cycles because of masking.
- Requester rules:
  - hold req and its data stable until the cycle gnt[i]=1;
  - on that edge it may drop req or present new data.
  - Dropping req before gnt is allowed; the request is simply not served.
- FSM states, from which the outputs are derived:
  - IDLE: no write.
  - WRITE: write issued this cycle.
  - STALL: eligible set non-zero but stall=1.
  - Transitions are evaluated every cycle from the eligible set and stall as above; any state can reach any state.
- Fairness: every continuously requesting producer is granted within NUM_REQ non-stalled write slots.
- Response check, latching arb_err=1 until reset:
  - fifo_overflow=1 in any cycle, or
  - fifo_wr_en=1 in cycle t and fifo_wr_ack=0 in cycle t+1.
- arb_err does not stop arbitration.
- Reset mid-operation: outputs clear immediately (async). A write in flight is lost; the ack check is cleared.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- When defined, adds outputs:
  - wr_count (16 bit): increments on each fifo_wr_en cycle, wraps at 0xFFFF→0.
  - stall_count (16 bit): increments each cycle in STALL, saturates at 0xFFFF.
  - Both reset to 0.
- When undefined, these ports and registers do not exist and the behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_e enum (IDLE, WRITE, STALL);
  - localparam STATS_W = 16;
  - function rr_next(idx, n).
- One sub-module, rr_pick: purely combinational rotate-priority picker. Inputs: eligible vector and pointer. Outputs: one-hot grant and index. It is instantiated once.

Test Plan:
- Single request: req=4'b0001, data 0xA5A5, empty FIFO → cycle t+1: gnt=0001, fifo_wr_en=1, fifo_din=0xA5A5; cycle t+2: wr_ack=1, arb_err=0.
- Contention: req=1111 held 8 cycles, data=index → grant order 0,1,2,3,0,1,2,3 as far as the FIFO allows, with no index granted twice in succession.
- Full throttle: FIFO depth 8, no reads, req=1111 continuously → exactly 8 writes, then fifo_wr_en=0, state STALL, fifo_overflow never asserted.
- Drain: from the full state, one FIFO read → exactly one further write, grant continuing from the rr pointer.
- Error: force fifo_overflow=1 for one cycle → arb_err=1, and it stays 1 until rst_n pulses low.
- Async reset: assert rst_n=0 mid-grant between clock edges → gnt, fifo_wr_en and arb_err drop immediately; after release, requester 0 has priority. With FIFO_ARB_STATS_EN, also check wr_count=8 and stall_count correct after the full-throttle case.
